// File: rtl/block_round_engine_pkg.sv
// Shared constants and FSM encoding for the DVB-CSA block decrypt engine.
//   ROUNDS     : rounds per block (one key byte per round)
//   BLK_W      : data block width
//   KEY_W      : expanded key width (ROUNDS key bytes)
//   CNT_W      : round counter width
//   state_t    : IDLE / RUN encoding
package block_round_engine_pkg;

    localparam int ROUNDS = 56;
    localparam int BLK_W  = 64;
    localparam int KEY_W  = 448;
    localparam int CNT_W  = 6;

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/block_perm.sv
// DVB-CSA block cipher bit permutation (combinational).
//   x : input byte
//   y : permuted byte
// Bit mapping: 0->1, 1->7, 2->5, 3->4, 4->2, 5->6, 6->0, 7->3.
module block_perm (
    input  logic [7:0] x,
    output logic [7:0] y
);

    assign y = {x[1], x[5], x[2], x[3], x[7], x[4], x[0], x[6]};

endmodule

// File: rtl/block_sbox.sv
// DVB-CSA block cipher 8-bit S-box (combinational table lookup).
//   x : input byte
//   y : substituted byte
module block_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    // Entry 0 sits in the most significant byte, so entry i lives at
    // bit offset 8*(255-i); 255-i is simply ~x for an 8-bit index.
    localparam logic [2047:0] TABLE = {
        128'h3aea68fe33e9881a83cfe17fbae23812,
        128'he82761950c36e570a206827c17a32649,
        128'hbe7a6d47c1518ff3cc5b67bdcd1808c9,
        128'hff69ef034e484a843fb41004dcf55cc6,
        128'h16abac4cf16a2f3c3bd4d594d0c46362,
        128'h71a1f94f2eaac556e33993ce6564e458,
        128'h6c194279ddee96f68aec1e855345debb,
        128'h7e0a9a132a9dc25e5a1f32359ca87330,
        128'h293de792871b2b4ba557974015e6bc0e,
        128'hebc3342db84425a41cc723ed906e5000,
        128'h999e4dd9da8d6f5f3ed7217486df6b05,
        128'h8e5d3711d22875d6a77724bff0b002b7,
        128'hf8fc8109b10176917d0fc8a0f2cb7860,
        128'hd1f7e0b59822b3201da6db7b599fae31,
        128'hfbd3b6ca437207f4d84114550d548bb9,
        128'had460baf80522cfa8c8966fdb2a99bc0
    };

    assign y = TABLE[{~x, 3'b000} +: 8];

endmodule

// File: rtl/block_round_engine.sv
// Iterative DVB-CSA block decrypt: one round per clock, 56 rounds per block.
//   clk, rst_n : clock, async active-low reset
//   start      : accept din/kk when idle
//   din        : ciphertext, byte i = din[8i+7:8i]
//   kk         : expanded key, byte k = kk[8k+7:8k]
//   busy       : decryption in progress
//   done       : one-cycle pulse, dout valid
//   dout       : plaintext, held until the next completion
module block_round_engine
    import block_round_engine_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BLK_W-1:0] din,
    input  logic [KEY_W-1:0] kk,
    output logic             busy,
    output logic             done,
    output logic [BLK_W-1:0] dout
);

    state_t           state, state_nxt;
    logic [7:0][7:0]  w, w_nxt;
    logic [CNT_W-1:0] cnt;
    logic [KEY_W-1:0] key;
    logic [7:0]       kbyte, sbox_in, s, ps, l;
    logic             last;
    logic             accept;

    // Rounds consume key bytes from the top (55) down to 0.
    assign kbyte   = key[{cnt, 3'b000} +: 8];
    assign sbox_in = kbyte ^ w[6];
    assign last    = (cnt == '0);
    assign accept  = (state == IDLE) && start;

    block_sbox u_sbox (.x(sbox_in), .y(s));
    block_perm u_perm (.x(s),       .y(ps));

    assign l = w[7] ^ s;
    // Byte 7 is the leftmost element of the concatenation.
    assign w_nxt = {w[6], w[5] ^ ps, w[4], w[3] ^ l, w[2] ^ l, w[1] ^ l, w[0], l};

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w    <= '0;
            cnt  <= '0;
            key  <= '0;
            dout <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                w   <= din;
                key <= kk;
                cnt <= LAST_ROUND;
            end else if (state == RUN) begin
                w <= w_nxt;
                if (last) begin
                    dout <= w_nxt;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule
